// File: rtl/ni_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ni_pkg
//  Description : Shared types and constants for the noninterference slot
//                scheduler: FSM state encoding, domain identifiers and a
//                helper that sizes the slot/flush counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ni_pkg;

    // Schedule phases, visited strictly in this order and wrapping around.
    typedef enum logic [1:0] {
        P_SLOT    = 2'd0,
        FLUSH_P2S = 2'd1,
        S_SLOT    = 2'd2,
        FLUSH_S2P = 2'd3
    } state_t;

    localparam logic DOM_PUB = 1'b0;
    localparam logic DOM_SEC = 1'b1;

    // Counter width = clog2(max(slot_len, flush_len)), never below one bit
    // so the counter stays a real register when both lengths are 1 or 2.
    function automatic int cnt_width(input int slot_len, input int flush_len);
        int m;
        m = (slot_len > flush_len) ? slot_len : flush_len;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ni_shared_acc.sv
`default_nettype none
// ============================================================================
//  Module      : ni_shared_acc
//  Description : DW-bit XOR accumulator shared by both domains. A clear
//                (scrub) wins over an enable.
//  Ports       : clock  - posedge clock
//                rst_n  - asynchronous active-low reset (acc -> 0)
//                en     - accumulate op into acc this cycle
//                clr    - scrub acc to zero this cycle
//                op     - operand to XOR in
//                acc    - current accumulator value
//  Revision    : 1.0 - initial release
// ============================================================================
module ni_shared_acc #(
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    input  logic [DW-1:0] op,
    output logic [DW-1:0] acc
);

    logic [DW-1:0] r_acc;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc ^ op;
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/ni_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ni_slot_scheduler
//  Description : Fixed time-partitioned scheduler sharing one XOR accumulator
//                between a public and a secret requester. Slots alternate
//                regardless of demand and the accumulator is scrubbed at each
//                domain switch, so public-side timing and data never depend
//                on secret inputs.
//  Ports       : clock, rst_n            - clock / async active-low reset
//                req_pub, op_pub         - public request and operand
//                req_sec, op_sec         - secret request and operand
//                gnt_pub, gnt_sec        - grant windows (combinational)
//                res_valid_pub, res_pub  - public result pulse / held value
//                res_valid_sec, res_sec  - secret result pulse / held value
//                dom                     - owner (0 pub, 1 sec), held in flush
//                scrub                   - flush in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module ni_slot_scheduler
    import ni_pkg::*;
#(
    parameter int DW        = 8,
    parameter int SLOT_LEN  = 4,
    parameter int FLUSH_LEN = 1
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          req_pub,
    input  logic [DW-1:0] op_pub,
    input  logic          req_sec,
    input  logic [DW-1:0] op_sec,
    output logic          gnt_pub,
    output logic          gnt_sec,
    output logic          res_valid_pub,
    output logic [DW-1:0] res_pub,
    output logic          res_valid_sec,
    output logic [DW-1:0] res_sec,
    output logic          dom,
    output logic          scrub
);

    localparam int                c_cnt_w      = cnt_width(SLOT_LEN, FLUSH_LEN);
    localparam logic [c_cnt_w-1:0] c_slot_last  = c_cnt_w'(SLOT_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_flush_last = c_cnt_w'(FLUSH_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_res_valid_pub;
    logic                 r_res_valid_sec;
    logic [DW-1:0]        r_res_pub;
    logic [DW-1:0]        r_res_sec;

    logic                 w_slot_done;
    logic                 w_flush_done;
    logic                 w_acc_pub;
    logic                 w_acc_sec;
    logic [DW-1:0]        w_op;
    logic [DW-1:0]        w_acc;
    logic [DW-1:0]        w_acc_next;

    assign w_slot_done  = (r_cnt == c_slot_last);
    assign w_flush_done = (r_cnt == c_flush_last);

    // ------------------------------------------------------------------
    // Schedule FSM: advances purely on the counter, never on requests.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= P_SLOT;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_one;
            case (r_state)
                P_SLOT: begin
                    if (w_slot_done) begin
                        r_state <= FLUSH_P2S;
                        r_cnt   <= '0;
                    end
                end
                FLUSH_P2S: begin
                    if (w_flush_done) begin
                        r_state <= S_SLOT;
                        r_cnt   <= '0;
                    end
                end
                S_SLOT: begin
                    if (w_slot_done) begin
                        r_state <= FLUSH_S2P;
                        r_cnt   <= '0;
                    end
                end
                FLUSH_S2P: begin
                    if (w_flush_done) begin
                        r_state <= P_SLOT;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= P_SLOT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // The last slot cycle is withheld as a guard so a result accepted in
    // the preceding cycle retires before the scrub starts.
    assign gnt_pub = (r_state == P_SLOT) && !w_slot_done;
    assign gnt_sec = (r_state == S_SLOT) && !w_slot_done;
    assign scrub   = (r_state == FLUSH_P2S) || (r_state == FLUSH_S2P);
    assign dom     = ((r_state == S_SLOT) || (r_state == FLUSH_S2P)) ? DOM_SEC : DOM_PUB;

    assign w_acc_pub  = req_pub & gnt_pub;
    assign w_acc_sec  = req_sec & gnt_sec;
    // Grants are mutually exclusive, so a plain select suffices.
    assign w_op       = w_acc_sec ? op_sec : op_pub;
    assign w_acc_next = w_acc ^ w_op;

    ni_shared_acc #(
        .DW (DW)
    ) u_acc (
        .clock (clock),
        .rst_n (rst_n),
        .en    (w_acc_pub | w_acc_sec),
        .clr   (scrub),
        .op    (w_op),
        .acc   (w_acc)
    );

    // ------------------------------------------------------------------
    // Per-domain result registers: each only ever loads on its own accept.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid_pub <= 1'b0;
            r_res_valid_sec <= 1'b0;
            r_res_pub       <= '0;
            r_res_sec       <= '0;
        end else begin
            r_res_valid_pub <= w_acc_pub;
            r_res_valid_sec <= w_acc_sec;
            if (w_acc_pub) begin
                r_res_pub <= w_acc_next;
            end
            if (w_acc_sec) begin
                r_res_sec <= w_acc_next;
            end
        end
    end

    assign res_valid_pub = r_res_valid_pub;
    assign res_valid_sec = r_res_valid_sec;
    assign res_pub       = r_res_pub;
    assign res_sec       = r_res_sec;

endmodule
`default_nettype wire

// File: tb/tb_ni_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ni_slot_scheduler
//  Description : Directed self-checking bench for ni_slot_scheduler. One
//                instance at default parameters, one with SLOT_LEN=2,
//                FLUSH_LEN=3. "Cycle k" is viewed just before edge k, where
//                edge 0 is the first rising edge after reset release.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ni_slot_scheduler;

    logic       clock = 1'b0;
    logic       rst_n;

    logic       req_pub, req_sec;
    logic [7:0] op_pub, op_sec;
    logic       gnt_pub, gnt_sec, res_valid_pub, res_valid_sec, dom, scrub;
    logic [7:0] res_pub, res_sec;

    logic       req_pub_b, req_sec_b;
    logic [7:0] op_pub_b, op_sec_b;
    logic       gnt_pub_b, gnt_sec_b, res_valid_pub_b, res_valid_sec_b, dom_b, scrub_b;
    logic [7:0] res_pub_b, res_sec_b;

    int checks = 0;
    int errors = 0;

    logic [11:0] trace_a [0:59];

    always #5 clock = ~clock;

    ni_slot_scheduler #(.DW(8), .SLOT_LEN(4), .FLUSH_LEN(1)) dut (
        .clock(clock), .rst_n(rst_n),
        .req_pub(req_pub), .op_pub(op_pub), .req_sec(req_sec), .op_sec(op_sec),
        .gnt_pub(gnt_pub), .gnt_sec(gnt_sec),
        .res_valid_pub(res_valid_pub), .res_pub(res_pub),
        .res_valid_sec(res_valid_sec), .res_sec(res_sec),
        .dom(dom), .scrub(scrub)
    );

    ni_slot_scheduler #(.DW(8), .SLOT_LEN(2), .FLUSH_LEN(3)) dut_b (
        .clock(clock), .rst_n(rst_n),
        .req_pub(req_pub_b), .op_pub(op_pub_b), .req_sec(req_sec_b), .op_sec(op_sec_b),
        .gnt_pub(gnt_pub_b), .gnt_sec(gnt_sec_b),
        .res_valid_pub(res_valid_pub_b), .res_pub(res_pub_b),
        .res_valid_sec(res_valid_sec_b), .res_sec(res_sec_b),
        .dom(dom_b), .scrub(scrub_b)
    );

    task automatic drive_idle();
        req_pub = 1'b0; op_pub = 8'h00; req_sec = 1'b0; op_sec = 8'h00;
        req_pub_b = 1'b0; op_pub_b = 8'h00; req_sec_b = 1'b0; op_sec_b = 8'h00;
    endtask

    // Leaves time at a falling edge with reset released: the cycle-0 view.
    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if ({gnt_pub, gnt_sec, res_valid_pub, res_valid_sec, dom, scrub} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 100000",
                     {gnt_pub, gnt_sec, res_valid_pub, res_valid_sec, dom, scrub});
        end
        checks++;
        if ({res_pub, res_sec} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_res: got %h want 0000", {res_pub, res_sec});
        end
        @(negedge clock);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({dom, gnt_pub} !== 2'b01) begin
            errors++;
            $display("FAIL reset_release: dom/gnt_pub got %b want 01", {dom, gnt_pub});
        end
    endtask

    // Back-to-back public accepts, latency 1, accumulation 05 ^ 03 = 06.
    task automatic test_accumulate();
        do_reset();
        req_pub = 1'b1; op_pub = 8'h05;
        checks++;
        if (res_valid_pub !== 1'b0) begin
            errors++;
            $display("FAIL acc_c0_valid: got %b want 0", res_valid_pub);
        end
        next_cycle();
        op_pub = 8'h03;
        checks++;
        if ({res_valid_pub, res_pub} !== {1'b1, 8'h05}) begin
            errors++;
            $display("FAIL acc_c1: valid/res got %b/%h want 1/05", res_valid_pub, res_pub);
        end
        next_cycle();
        req_pub = 1'b0;
        checks++;
        if ({res_valid_pub, res_pub} !== {1'b1, 8'h06}) begin
            errors++;
            $display("FAIL acc_c2: valid/res got %b/%h want 1/06", res_valid_pub, res_pub);
        end
        next_cycle();
        checks++;
        if ({res_valid_pub, res_pub} !== {1'b0, 8'h06}) begin
            errors++;
            $display("FAIL acc_c3_hold: valid/res got %b/%h want 0/06", res_valid_pub, res_pub);
        end
    endtask

    // Guard cycle and flush: request held over cycles 0..4.
    task automatic test_guard_flush();
        logic [4:0] got, want;
        do_reset();
        for (int k = 0; k <= 5; k++) begin
            req_pub = (k <= 4);
            op_pub  = 8'h01;
            got  = {gnt_pub, scrub, res_valid_pub, dom, gnt_sec};
            want = {(k <= 2), (k == 4), (k >= 1 && k <= 3), (k == 5), (k == 5)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL guard_flush c%0d: gnt_pub/scrub/valid/dom/gnt_sec got %b want %b",
                         k, got, want);
            end
            if (k == 3) begin
                // Accepts at cycles 0,1,2 of 01: 01, 00, 01
                checks++;
                if (res_pub !== 8'h01) begin
                    errors++;
                    $display("FAIL guard_res: got %h want 01", res_pub);
                end
            end
            next_cycle();
        end
        req_pub = 1'b0;
    endtask

    // Secret result is unaffected by prior public data; public result
    // after the switch-back is unaffected by secret data.
    task automatic test_scrub();
        do_reset();
        for (int k = 0; k <= 11; k++) begin
            req_pub = (k == 0) || (k == 10);
            op_pub  = (k == 0) ? 8'h5A : 8'h01;
            req_sec = (k == 5);
            op_sec  = 8'hAA;
            if (k == 6) begin
                checks++;
                if ({res_valid_sec, res_sec} !== {1'b1, 8'hAA}) begin
                    errors++;
                    $display("FAIL scrub_sec: valid/res got %b/%h want 1/aa", res_valid_sec, res_sec);
                end
                checks++;
                if ({res_valid_pub, res_pub} !== {1'b0, 8'h5A}) begin
                    errors++;
                    $display("FAIL scrub_pub_iso: valid/res got %b/%h want 0/5a", res_valid_pub, res_pub);
                end
            end
            if (k == 11) begin
                checks++;
                if ({res_valid_pub, res_pub} !== {1'b1, 8'h01}) begin
                    errors++;
                    $display("FAIL scrub_pub: valid/res got %b/%h want 1/01", res_valid_pub, res_pub);
                end
            end
            next_cycle();
        end
        drive_idle();
    endtask

    // Same public stimulus, different random secret stimulus, twice.
    task automatic test_noninterference();
        logic [11:0] obs;
        for (int run = 0; run < 2; run++) begin
            do_reset();
            for (int k = 0; k < 60; k++) begin
                req_pub = ((k % 3) != 1);
                op_pub  = 8'(k * 7 + 3);
                req_sec = 1'($urandom_range(0, 1));
                op_sec  = 8'($urandom_range(0, 255));
                obs = {gnt_pub, res_valid_pub, res_pub, dom, scrub};
                if (run == 0) begin
                    trace_a[k] = obs;
                end else begin
                    checks++;
                    if (obs !== trace_a[k]) begin
                        errors++;
                        $display("FAIL ni_trace c%0d: got %h want %h", k, obs, trace_a[k]);
                    end
                end
                next_cycle();
            end
        end
        drive_idle();
    endtask

    // Asynchronous reset in the middle of a secret slot with a pending pulse.
    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k <= 6; k++) begin
            req_sec = (k >= 5);
            op_sec  = 8'hAA;
            if (k < 6) next_cycle();
        end
        checks++;
        if ({res_valid_sec, dom} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_pre: valid_sec/dom got %b want 11", {res_valid_sec, dom});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt_pub, gnt_sec, res_valid_pub, res_valid_sec, dom, scrub} !== 6'b100000) begin
            errors++;
            $display("FAIL rst_mid_ctl: got %b want 100000",
                     {gnt_pub, gnt_sec, res_valid_pub, res_valid_sec, dom, scrub});
        end
        checks++;
        if ({res_pub, res_sec} !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_res: got %h want 0000", {res_pub, res_sec});
        end
        drive_idle();
        @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({dom, gnt_pub} !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid_release: dom/gnt_pub got %b want 01", {dom, gnt_pub});
        end
        req_pub = 1'b1; op_pub = 8'h01;
        next_cycle();
        req_pub = 1'b0;
        checks++;
        if ({res_valid_pub, res_pub} !== {1'b1, 8'h01}) begin
            errors++;
            $display("FAIL rst_mid_acc: valid/res got %b/%h want 1/01", res_valid_pub, res_pub);
        end
    endtask

    // SLOT_LEN=2, FLUSH_LEN=3: one grant cycle per slot, three scrub cycles.
    task automatic test_short_slots();
        logic [3:0] got, want;
        int p;
        do_reset();
        req_pub_b = 1'b1; op_pub_b = 8'h11;
        req_sec_b = 1'b1; op_sec_b = 8'h22;
        for (int k = 0; k < 20; k++) begin
            p = k % 10;
            got  = {gnt_pub_b, gnt_sec_b, scrub_b, dom_b};
            want = {(p == 0), (p == 5), ((p >= 2 && p <= 4) || p >= 7), (p >= 5)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL short c%0d: gnt_pub/gnt_sec/scrub/dom got %b want %b", k, got, want);
            end
            if (p == 1) begin
                checks++;
                if ({res_valid_pub_b, res_pub_b} !== {1'b1, 8'h11}) begin
                    errors++;
                    $display("FAIL short_pub c%0d: valid/res got %b/%h want 1/11", k, res_valid_pub_b, res_pub_b);
                end
            end
            if (p == 6) begin
                checks++;
                if ({res_valid_sec_b, res_sec_b} !== {1'b1, 8'h22}) begin
                    errors++;
                    $display("FAIL short_sec c%0d: valid/res got %b/%h want 1/22", k, res_valid_sec_b, res_sec_b);
                end
            end
            next_cycle();
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_guard_flush();
        test_scrub();
        test_noninterference();
        test_reset_mid();
        test_short_slots();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
